fp16_mul_result_buffer: RTL

Downstream companion to the 9-cycle fp16_multiplier. The multiplier has no valid, no stall and no reset, so this block supplies them:
- tracks which multiplier pipeline slots hold real operands;
- captures each result into a credit-protected FIFO;
- presents results on a ready/valid interface.
It also issues credits upstream, so the operand source never launches a product that cannot be stored.

---
 rtl/fp16_pkg.sv | 29 ++
 rtl/fp16_sync_fifo.sv | 62 ++++++
 rtl/fp16_mul_result_buffer.sv | 72 +++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 constants and a result classifier used by the multiplier result buffer.
// The classifier feeds the optional FP16_RESBUF_FLAGS_EN flag path.
package fp16_pkg;

    localparam int FP16_W      = 16;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;

    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7e00;
    localparam logic [FP16_W-2:0] FP16_INF  = 15'h7c00;

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;
    localparam int FP16_FLAGS_W = 3;

    // Infinity is the only encoding with an all-ones exponent and a zero fraction, so it is one compare.
    function automatic logic [FP16_FLAGS_W-1:0] fp16_classify(input logic [FP16_W-1:0] v);
        logic [FP16_EXP_W-1:0]  e;
        logic [FP16_FRAC_W-1:0] f;
        fp16_classify = '0;
        e = v[FP16_W-2:FP16_FRAC_W];
        f = v[FP16_FRAC_W-1:0];
        fp16_classify[FLAG_NAN]  = (e == '1) && (f != '0);
        fp16_classify[FLAG_INF]  = (v[FP16_W-2:0] == FP16_INF);
        fp16_classify[FLAG_ZERO] = (v[FP16_W-2:0] == '0);
    endfunction

endpackage

// File: rtl/fp16_sync_fifo.sv
// Synchronous FIFO with async reset, occupancy output and wrap-around pointers for any DEPTH >= 2.
module fp16_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = wr_en_i && (count_q != CNT_W'(DEPTH));
    assign pop  = rd_en_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero until the first write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o   = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;

endmodule

// File: rtl/fp16_mul_result_buffer.sv
// Valid tracking, credit flow control and result FIFO for the unstallable fp16_multiplier.
// Define FP16_RESBUF_FLAGS_EN to store and present {nan, inf, zero} flags with each result.
module fp16_mul_result_buffer
    import fp16_pkg::*;
#(
    parameter int MUL_LATENCY = 9,
    parameter int DEPTH       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [FP16_W-1:0]       mul_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [FP16_W-1:0]       res_data,
    output logic [FP16_FLAGS_W-1:0] res_flags
);

    localparam int CNT_W = $clog2(DEPTH+1);
`ifdef FP16_RESBUF_FLAGS_EN
    localparam int ENTRY_W = FP16_W + FP16_FLAGS_W;
`else
    localparam int ENTRY_W = FP16_W;
`endif

    logic [MUL_LATENCY-1:0] vs_q, vs_d;
    logic [CNT_W-1:0]       occupancy, vs_count, credit_sum;
    logic                   issue_fire;
    logic [ENTRY_W-1:0]     wr_entry, head_entry;

    // Every live pipeline slot has a FIFO entry reserved, so credits are counted before results land.
    always_comb begin
        vs_count = '0;
        for (int i = 0; i < MUL_LATENCY; i++) vs_count = vs_count + CNT_W'(vs_q[i]);
    end

    assign credit_sum  = occupancy + vs_count;
    assign issue_ready = credit_sum < CNT_W'(DEPTH);
    assign issue_fire  = issue_valid && issue_ready;
    assign vs_d        = {vs_q[MUL_LATENCY-2:0], issue_fire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vs_q <= '0;
        else     vs_q <= vs_d;
    end

`ifdef FP16_RESBUF_FLAGS_EN
    assign wr_entry  = {fp16_classify(mul_out), mul_out};
    assign res_flags = head_entry[ENTRY_W-1:FP16_W];
`else
    assign wr_entry  = mul_out;
    assign res_flags = '0;
`endif

    assign res_data  = head_entry[FP16_W-1:0];
    assign res_valid = (occupancy != '0);

    fp16_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (vs_q[MUL_LATENCY-1]),
        .wr_data_i   (wr_entry),
        .rd_en_i     (res_ready),
        .rd_data_o   (head_entry),
        .occupancy_o (occupancy)
    );

endmodule
